// File: rtl/vtg_pkg.sv
// vtg_pkg: shared types and helpers for the video timing generator.
//   vtg_timing_t  - one axis of raster timing (active/front porch/sync/back porch)
//   vtg_region_e  - which part of an axis a count falls in
//   cnt_w()       - counter width for the given totals
//   region_of()   - classify a count against an axis timing
package vtg_pkg;

  typedef struct packed {
    logic [15:0] active;
    logic [15:0] fp;
    logic [15:0] sync;
    logic [15:0] bp;
  } vtg_timing_t;

  typedef enum logic [1:0] {ACTIVE, FP, SYNC, BP} vtg_region_e;

  // One spare count of headroom so an interlaced field with an extra line
  // (vcount == V_TOTAL) still fits.
  function automatic int cnt_w(input int h_total, input int v_total);
    int m;
    m = (h_total > v_total) ? h_total : v_total;
    return (m < 2) ? 1 : $clog2(m + 1);
  endfunction

  function automatic vtg_region_e region_of(input logic [15:0] count,
                                            input vtg_timing_t t);
    if (count < t.active)                 return ACTIVE;
    if (count < t.active + t.fp)          return FP;
    if (count < t.active + t.fp + t.sync) return SYNC;
    return BP;
  endfunction

endpackage

// File: rtl/video_timing_gen_if.sv
// video_timing_gen_if: raster timing bundle between the timing source and
// pixel consumers.
//   master: drives pix_ce, hblank, vblank, hs, vs, de, hcount, vcount
//           (and field); takes enable (and interlace).
//   slave : the consumer view.
// With VIDEO_TIMING_INTERLACE_EN defined, interlace/field are added.
interface video_timing_gen_if #(parameter int CNT_W = 9);
  logic             enable;
  logic             pix_ce;
  logic             hblank;
  logic             vblank;
  logic             hs;
  logic             vs;
  logic             de;
  logic [CNT_W-1:0] hcount;
  logic [CNT_W-1:0] vcount;
`ifdef VIDEO_TIMING_INTERLACE_EN
  logic             interlace;
  logic             field;
`endif

  modport master (
    input  enable,
`ifdef VIDEO_TIMING_INTERLACE_EN
    input  interlace,
    output field,
`endif
    output pix_ce, hblank, vblank, hs, vs, de, hcount, vcount
  );

  modport slave (
    output enable,
`ifdef VIDEO_TIMING_INTERLACE_EN
    output interlace,
    input  field,
`endif
    input  pix_ce, hblank, vblank, hs, vs, de, hcount, vcount
  );
endinterface

// File: rtl/vtg_axis_counter.sv
// vtg_axis_counter: one raster axis (horizontal or vertical).
//   clk, reset : clock, async active-high reset
//   timing     : axis timing (may change at a wrap, e.g. interlace extra line)
//   advance    : step the count this cycle
//   count      : current position, 0..total-1
//   blank/sync : registered region flags for the count currently output
//   wrap       : combinational, high on the advancing edge that returns to 0
module vtg_axis_counter
  import vtg_pkg::*;
#(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  vtg_timing_t      timing,
  input  logic             advance,
  output logic [CNT_W-1:0] count,
  output logic             blank,
  output logic             sync,
  output logic             wrap
);

  logic [15:0]      total;
  logic [CNT_W-1:0] nxt;
  vtg_region_e      nxt_region;

  assign total      = timing.active + timing.fp + timing.sync + timing.bp;
  assign wrap       = advance && (16'(count) == total - 16'd1);
  assign nxt        = wrap ? '0 : count + CNT_W'(1);
  // Flags come from the next count so they line up with count on output.
  assign nxt_region = region_of(16'(nxt), timing);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      blank <= 1'b0;
      sync  <= 1'b0;
    end else if (advance) begin
      count <= nxt;
      blank <= (nxt_region != ACTIVE);
      sync  <= (nxt_region == SYNC);
    end
  end

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: programmable raster timing source.
//   clk, reset : clock, async active-high reset
//   vt         : video_timing_gen_if.master (enable in; pix_ce, hblank,
//                vblank, hs, vs, de, hcount, vcount out)
// Optional: VIDEO_TIMING_INTERLACE_EN adds interlace in / field out with an
// extra back-porch line and half-line vsync offset in field 1.
module video_timing_gen
  import vtg_pkg::*;
#(
  parameter int H_ACTIVE = 320,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 32,
  parameter int H_BP     = 32,
  parameter int V_ACTIVE = 240,
  parameter int V_FP     = 3,
  parameter int V_SYNC   = 3,
  parameter int V_BP     = 16,
  parameter int CE_DIV   = 4,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0
) (
  input logic              clk,
  input logic              reset,
  video_timing_gen_if.master vt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CNT_W   = cnt_w(H_TOTAL, V_TOTAL);

  localparam vtg_timing_t H_TIM = '{active: 16'(H_ACTIVE), fp: 16'(H_FP),
                                    sync: 16'(H_SYNC), bp: 16'(H_BP)};

  generate
    if (H_ACTIVE == 0 || H_SYNC == 0 || V_ACTIVE == 0 || V_SYNC == 0) begin : g_bad_len
      $error("video_timing_gen: active and sync lengths must be non-zero");
    end
    if (CE_DIV < 1 || CE_DIV > 16) begin : g_bad_div
      $error("video_timing_gen: CE_DIV must be 1..16");
    end
  endgenerate

  // Divider. pix_ce_q freezes with everything else while enable is low, so a
  // pending pixel strobe survives a pause; the port is gated by enable.
  logic [3:0] div_cnt;
  logic       pix_ce_q;
  logic       adv;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt  <= '0;
      pix_ce_q <= 1'b0;
    end else if (vt.enable) begin
      pix_ce_q <= (div_cnt == 4'(CE_DIV - 1));
      div_cnt  <= (div_cnt == 4'(CE_DIV - 1)) ? '0 : div_cnt + 4'd1;
    end
  end

  assign adv       = pix_ce_q & vt.enable;
  assign vt.pix_ce = adv;

  logic        h_sync, v_sync, h_wrap, vs_act;
  vtg_timing_t v_tim;

  vtg_axis_counter #(.CNT_W(CNT_W)) u_h (
    .clk(clk), .reset(reset), .timing(H_TIM), .advance(adv),
    .count(vt.hcount), .blank(vt.hblank), .sync(h_sync), .wrap(h_wrap)
  );

`ifdef VIDEO_TIMING_INTERLACE_EN
  logic v_wrap;

  vtg_axis_counter #(.CNT_W(CNT_W)) u_v (
    .clk(clk), .reset(reset), .timing(v_tim), .advance(h_wrap),
    .count(vt.vcount), .blank(vt.vblank), .sync(v_sync), .wrap(v_wrap)
  );

  localparam int S0   = V_ACTIVE + V_FP;
  localparam int S1   = S0 + V_SYNC;
  localparam int HALF = H_TOTAL / 2;

  logic             field_q, field_nxt, vs_q, vs_nxt;
  logic [CNT_W-1:0] h_nxt, v_nxt;

  // Field 1 carries one extra line in the back porch.
  assign v_tim = '{active: 16'(V_ACTIVE), fp: 16'(V_FP), sync: 16'(V_SYNC),
                   bp: 16'(V_BP) + {15'd0, field_q}};

  assign field_nxt = v_wrap ? (vt.interlace & ~field_q) : field_q;
  assign h_nxt     = h_wrap ? '0 : vt.hcount + CNT_W'(1);
  assign v_nxt     = v_wrap ? '0 : (h_wrap ? vt.vcount + CNT_W'(1) : vt.vcount);

  // Field 1 vsync is shifted by half a line relative to field 0.
  always_comb begin
    vs_nxt = (v_nxt >= CNT_W'(S0)) && (v_nxt < CNT_W'(S1));
    if (field_nxt)
      vs_nxt = (vs_nxt && h_nxt >= CNT_W'(HALF)) ||
               (v_nxt == CNT_W'(S1) && h_nxt < CNT_W'(HALF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      field_q <= 1'b0;
      vs_q    <= 1'b0;
    end else if (adv) begin
      field_q <= field_nxt;
      vs_q    <= vs_nxt;
    end
  end

  assign vs_act   = vs_q;
  assign vt.field = field_q;
`else
  logic unused_v_wrap;

  assign v_tim = '{active: 16'(V_ACTIVE), fp: 16'(V_FP),
                   sync: 16'(V_SYNC), bp: 16'(V_BP)};

  vtg_axis_counter #(.CNT_W(CNT_W)) u_v (
    .clk(clk), .reset(reset), .timing(v_tim), .advance(h_wrap),
    .count(vt.vcount), .blank(vt.vblank), .sync(v_sync), .wrap(unused_v_wrap)
  );

  assign vs_act = v_sync;
`endif

  assign vt.hs = (HS_POL != 0) ? h_sync : ~h_sync;
  assign vt.vs = (VS_POL != 0) ? vs_act : ~vs_act;
  assign vt.de = ~vt.hblank & ~vt.vblank;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb_video_timing_gen: two instances (CE_DIV=2 active-low syncs, and
// CE_DIV=1 with active-high hs) on a 14x7 raster, compared every clk against
// an arithmetic model: pixel index = f(enabled clocks since reset).
module tb_video_timing_gen;
  import vtg_pkg::*;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int CW = cnt_w(HT, VT);

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b1;
  int   n_tests = 0, n_fail = 0;
  int   ka = 0, kb = 0;

  always #5 clk = ~clk;

  video_timing_gen_if #(.CNT_W(CW)) vif_a ();
  video_timing_gen_if #(.CNT_W(CW)) vif_b ();

  assign vif_a.enable = en;
  assign vif_b.enable = 1'b1;
`ifdef VIDEO_TIMING_INTERLACE_EN
  assign vif_a.interlace = 1'b0;
  assign vif_b.interlace = 1'b0;
`endif

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CE_DIV(2), .HS_POL(0), .VS_POL(0)
  ) dut_a (.clk(clk), .reset(reset), .vt(vif_a));

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .CE_DIV(1), .HS_POL(1), .VS_POL(0)
  ) dut_b (.clk(clk), .reset(reset), .vt(vif_b));

  typedef struct {
    int pix_ce, hcount, vcount, hblank, vblank, hs, vs, de;
  } obs_t;

  // k = enabled clk edges since reset release. pix_ce is up after every
  // ce-th edge; pixel p advances one edge after each pix_ce.
  function automatic obs_t model(int k, bit en_now, int ce, bit hpol);
    obs_t m;
    int p, h, v;
    bit hact, vact;
    p    = (k == 0) ? 0 : (k - 1) / ce;
    h    = p % HT;
    v    = (p / HT) % VT;
    hact = (h >= HA + HF) && (h < HA + HF + HSW);
    vact = (v >= VA + VF) && (v < VA + VF + VSW);
    m.pix_ce = int'(en_now && k > 0 && (k % ce) == 0);
    m.hcount = h;
    m.vcount = v;
    m.hblank = int'(h >= HA);
    m.vblank = int'(v >= VA);
    m.hs     = int'(hpol ? hact : !hact);
    m.vs     = int'(!vact);
    m.de     = int'(h < HA && v < VA);
    return m;
  endfunction

  function automatic obs_t grab_a();
    obs_t m;
    m.pix_ce = int'(vif_a.pix_ce); m.hcount = int'(vif_a.hcount);
    m.vcount = int'(vif_a.vcount); m.hblank = int'(vif_a.hblank);
    m.vblank = int'(vif_a.vblank); m.hs = int'(vif_a.hs);
    m.vs = int'(vif_a.vs);         m.de = int'(vif_a.de);
    return m;
  endfunction

  function automatic obs_t grab_b();
    obs_t m;
    m.pix_ce = int'(vif_b.pix_ce); m.hcount = int'(vif_b.hcount);
    m.vcount = int'(vif_b.vcount); m.hblank = int'(vif_b.hblank);
    m.vblank = int'(vif_b.vblank); m.hs = int'(vif_b.hs);
    m.vs = int'(vif_b.vs);         m.de = int'(vif_b.de);
    return m;
  endfunction

  task automatic chk(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp(input string pfx, input obs_t g, input obs_t e);
    chk({pfx, ".pix_ce"}, g.pix_ce, e.pix_ce);
    chk({pfx, ".hcount"}, g.hcount, e.hcount);
    chk({pfx, ".vcount"}, g.vcount, e.vcount);
    chk({pfx, ".hblank"}, g.hblank, e.hblank);
    chk({pfx, ".vblank"}, g.vblank, e.vblank);
    chk({pfx, ".hs"},     g.hs,     e.hs);
    chk({pfx, ".vs"},     g.vs,     e.vs);
    chk({pfx, ".de"},     g.de,     e.de);
  endtask

  // One clk: count the edge in the model, then check both DUTs mid-cycle.
  task automatic step();
    @(posedge clk);
    if (!reset) begin
      if (en) ka++;
      kb++;
    end
    @(negedge clk);
    cmp("a", grab_a(), model(ka, en, 2, 1'b0));
    cmp("b", grab_b(), model(kb, 1'b1, 1, 1'b1));
  endtask

  initial begin
    int pulses, dec;
    bit hit;

    // Reset values while reset is held.
    #2;
    cmp("rst_a", grab_a(), model(0, 1'b1, 2, 1'b0));
    cmp("rst_b", grab_b(), model(0, 1'b1, 1, 1'b1));
    @(negedge clk);
    reset = 1'b0;

    // First frame: count visible pixels over 98 pixel strobes.
    pulses = 0;
    dec    = 0;
    for (int i = 0; i < 400 && pulses < 98; i++) begin
      step();
      if (vif_a.pix_ce) begin
        pulses++;
        if (vif_a.de) dec++;
      end
    end
    chk("frame_pulses", pulses, 98);
    chk("de_per_frame", dec, 32);
    for (int i = 0; i < 4; i++) step();

    // Pause at hcount 5 for 7 clks, then resume.
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      step();
      if (vif_a.hcount == CW'(5)) hit = 1'b1;
    end
    chk("reach_h5", int'(hit), 1);
    en = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step();
      chk("hold_h", int'(vif_a.hcount), 5);
    end
    en  = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 10 && !hit; i++) begin
      step();
      if (vif_a.pix_ce) hit = 1'b1;
    end
    chk("resume_ce", int'(hit), 1);
    step();
    chk("resume_h", int'(vif_a.hcount), 6);

    // Random enable pattern.
    for (int i = 0; i < 300; i++) begin
      en = ($urandom_range(0, 3) != 0);
      step();
    end
    en = 1'b1;

    // Asynchronous reset while hs and vs are both active.
    hit = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      step();
      if (vif_a.hcount == CW'(11) && vif_a.vcount == CW'(5)) hit = 1'b1;
    end
    chk("reach_h11v5", int'(hit), 1);
    chk("pre_rst_hs", int'(vif_a.hs), 0);
    chk("pre_rst_vs", int'(vif_a.vs), 0);
    #2 reset = 1'b1;
    ka = 0;
    kb = 0;
    #1;
    cmp("async_a", grab_a(), model(0, 1'b1, 2, 1'b0));
    cmp("async_b", grab_b(), model(0, 1'b1, 1, 1'b1));
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 120; i++) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
